// File: rtl/mem_word_adapter_if.sv
// Byte-wide request bus between an upstream stage and memory_system.
// busy is registered on the provider side and rises the cycle after a dispatch.
interface memory_bus;
    logic [31:0] addr;
    logic [7:0]  write_data;
    logic        dispatch_read;
    logic        dispatch_write;
    logic [7:0]  read_data;
    logic        busy;

    modport CONSUMER (
        output addr, write_data, dispatch_read, dispatch_write,
        input  read_data, busy
    );

    modport PROVIDER (
        input  addr, write_data, dispatch_read, dispatch_write,
        output read_data, busy
    );
endinterface

// File: rtl/mem_word_adapter.sv
// Splits one 8/16/32-bit load/store into single-byte bus transactions and
// assembles little-endian load data; bad size/alignment answers without bus traffic.
module mem_word_adapter #(
    parameter bit          CHECK_ALIGN = 1'b1,
    parameter logic [31:0] ERR_RDATA   = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    memory_bus.CONSUMER bus
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ERR} state_t;

    state_t      state_reg, state_next;
    logic        write_reg, signed_reg;
    logic [1:0]  size_reg, cnt_reg;
    logic [31:0] addr_reg, wdata_reg, rdata_reg;
    logic        ready_reg, resp_valid_reg, resp_error_reg;
    logic [31:0] resp_rdata_reg;

    logic        accept, misaligned, req_error, byte_done, last_byte;
    logic [1:0]  last_idx;
    logic [31:0] merged, load_result;

    assign accept     = req_valid && ready_reg;
    assign misaligned = (req_size == 2'd1 && req_addr[0]) ||
                        (req_size == 2'd2 && req_addr[1:0] != 2'b00);
    assign req_error  = (req_size == 2'd3) || (CHECK_ALIGN && misaligned);
    assign last_idx   = (size_reg == 2'd0) ? 2'd0 : (size_reg == 2'd1) ? 2'd1 : 2'd3;
    assign last_byte  = (cnt_reg == last_idx);
    assign byte_done  = (state_reg == WAIT) && !bus.busy;

    // Read data as it will look once the byte arriving this cycle is included.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merged[8*gi +: 8] = (cnt_reg == 2'(gi)) ? bus.read_data
                                                           : rdata_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        load_result = merged;
        case (size_reg)
            2'd0:    load_result = {{24{signed_reg & merged[7]}},  merged[7:0]};
            2'd1:    load_result = {{16{signed_reg & merged[15]}}, merged[15:0]};
            default: load_result = merged;
        endcase
    end

    always_comb begin
        state_next         = state_reg;
        bus.dispatch_read  = 1'b0;
        bus.dispatch_write = 1'b0;
        case (state_reg)
            IDLE:  if (accept) state_next = req_error ? ERR : ISSUE;
            ISSUE: begin
                if (!bus.busy) begin
                    bus.dispatch_write = write_reg;
                    bus.dispatch_read  = !write_reg;
                    state_next         = WAIT;
                end
            end
            WAIT:  if (!bus.busy) state_next = last_byte ? RESP : ISSUE;
            RESP:  state_next = IDLE;
            ERR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg      <= IDLE;
            write_reg      <= 1'b0;
            signed_reg     <= 1'b0;
            size_reg       <= 2'd0;
            cnt_reg        <= 2'd0;
            addr_reg       <= 32'h0;
            wdata_reg      <= 32'h0;
            rdata_reg      <= 32'h0;
            ready_reg      <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_error_reg <= 1'b0;
            resp_rdata_reg <= 32'h0;
        end else begin
            state_reg      <= state_next;
            ready_reg      <= (state_next == IDLE);
            resp_valid_reg <= (state_next == RESP) || (state_next == ERR);

            if (state_reg == IDLE && accept) begin
                write_reg  <= req_write;
                signed_reg <= req_signed;
                size_reg   <= req_size;
                cnt_reg    <= 2'd0;
                rdata_reg  <= 32'h0;
                // Rejected requests leave the bus address and data untouched.
                if (!req_error) begin
                    addr_reg  <= req_addr;
                    wdata_reg <= req_wdata;
                end
            end

            if (byte_done) begin
                if (!write_reg) rdata_reg <= merged;
                if (!last_byte) begin
                    cnt_reg   <= cnt_reg + 2'd1;
                    addr_reg  <= addr_reg + 32'd1;
                    wdata_reg <= {8'h00, wdata_reg[31:8]};
                end
            end

            if (state_next == ERR) begin
                resp_rdata_reg <= ERR_RDATA;
                resp_error_reg <= 1'b1;
            end else if (state_next == RESP) begin
                resp_rdata_reg <= write_reg ? 32'h0 : load_result;
                resp_error_reg <= 1'b0;
            end
        end
    end

    assign req_ready      = ready_reg;
    assign resp_valid     = resp_valid_reg;
    assign resp_rdata     = resp_rdata_reg;
    assign resp_error     = resp_error_reg;
    assign bus.addr       = addr_reg;
    assign bus.write_data = wdata_reg[7:0];

endmodule

// File: tb/tb_mem_word_adapter.sv
// Bench for mem_word_adapter: two instances (alignment checked / unchecked) on
// a byte-memory bus model, directed table, corner sequences and random requests.
module tb_mem_word_adapter;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        rst_in;
    logic [1:0]  req_valid_v, req_ready_v, resp_valid_v, resp_error_v;
    logic [31:0] resp_rdata_v [2];
    logic        req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;

    logic [1:0]  busy_v = 2'b00;
    logic [7:0]  rd_v [2] = '{8'h00, 8'h00};
    logic [1:0]  dr_v, dw_v;
    logic [31:0] ba_v [2];
    logic [7:0]  bw_v [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            memory_bus bus_i ();
            assign bus_i.busy      = busy_v[gi];
            assign bus_i.read_data = rd_v[gi];
            assign dr_v[gi]        = bus_i.dispatch_read;
            assign dw_v[gi]        = bus_i.dispatch_write;
            assign ba_v[gi]        = bus_i.addr;
            assign bw_v[gi]        = bus_i.write_data;

            mem_word_adapter #(
                .CHECK_ALIGN (gi == 0),
                .ERR_RDATA   ((gi == 0) ? 32'h0 : 32'hDEAD0BAD)
            ) dut (
                .clk_in     (clk_in),
                .rst_in     (rst_in),
                .req_valid  (req_valid_v[gi]),
                .req_ready  (req_ready_v[gi]),
                .req_write  (req_write),
                .req_size   (req_size),
                .req_signed (req_signed),
                .req_addr   (req_addr),
                .req_wdata  (req_wdata),
                .resp_valid (resp_valid_v[gi]),
                .resp_rdata (resp_rdata_v[gi]),
                .resp_error (resp_error_v[gi]),
                .bus        (bus_i)
            );
        end
    endgenerate

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory and bus model ----------------
    logic [7:0] mem    [logic [31:0]];
    logic [7:0] shadow [logic [31:0]];

    typedef struct { int k; bit w; logic [31:0] a; logic [7:0] d; } disp_t;
    disp_t disp_q [$];

    int          bus_lat    = 1;
    logic        force_busy = 1'b0;
    int          left [2]   = '{0, 0};
    logic [31:0] held_addr [2];
    logic [1:0]  prev_disp  = 2'b00;

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] sh_rd(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : 8'h00;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        mem[a]    = d;
        shadow[a] = d;
    endtask

    always @(posedge clk_in) begin
        for (int k = 0; k < 2; k++) begin
            if (dr_v[k] === 1'b1 || dw_v[k] === 1'b1) begin
                chk("disp_while_busy", 32'(busy_v[k]), 32'h0);
                chk("disp_both", 32'(dr_v[k] & dw_v[k]), 32'h0);
                chk("disp_width", 32'(prev_disp[k]), 32'h0);
                disp_q.push_back('{k, dw_v[k], ba_v[k], bw_v[k]});
                if (dw_v[k]) mem[ba_v[k]] = bw_v[k];
                rd_v[k]      <= mem_rd(ba_v[k]);
                busy_v[k]    <= 1'b1;
                left[k]       = bus_lat;
                held_addr[k]  = ba_v[k];
            end else begin
                if (busy_v[k] && left[k] > 0) chk("addr_stable", ba_v[k], held_addr[k]);
                if (left[k] > 0) left[k]--;
                busy_v[k] <= (left[k] > 0) || force_busy;
            end
            prev_disp[k] <= (dr_v[k] === 1'b1) || (dw_v[k] === 1'b1);
        end
    end

    // ---------------- reference model ----------------
    function automatic void ref_model(input int k, input bit w, input logic [1:0] size,
                                      input bit sgn, input logic [31:0] addr,
                                      input logic [31:0] wdata, input int blat,
                                      output logic [31:0] e_rdata, output bit e_err,
                                      output int e_lat);
        int          n;
        longint      v;
        bit          mis;
        logic [31:0] a;
        n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        mis   = (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
        e_err = (size == 2'd3) || (k == 0 && mis);
        if (e_err) begin
            e_rdata = (k == 0) ? 32'h0 : 32'hDEAD0BAD;
            e_lat   = 1;
            return;
        end
        e_lat = n * (2 + blat) + 1;
        v     = 0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            if (w) shadow[a] = wdata[8*i +: 8];
            else   v += longint'(sh_rd(a)) << (8 * i);
        end
        if (!w && sgn && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        e_rdata = w ? 32'h0 : v[31:0];
    endfunction

    // ---------------- request driver ----------------
    task automatic start_req(input int k, input bit w, input logic [1:0] size, input bit sgn,
                             input logic [31:0] addr, input logic [31:0] wdata);
        int cyc = 0;
        while (req_ready_v[k] !== 1'b1 && cyc < 50) begin
            @(negedge clk_in);
            cyc++;
        end
        chk("ready_before_req", 32'(req_ready_v[k]), 32'h1);
        req_write  = w;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid_v[k] = 1'b1;
        @(negedge clk_in);
        req_valid_v[k] = 1'b0;
    endtask

    task automatic wait_resp(input int k, output logic [31:0] rdata, output bit err,
                             output int lat);
        lat = 0;
        while (1) begin
            lat++;
            if (resp_valid_v[k] === 1'b1) break;
            if (lat >= 400) begin
                n_checks++;
                n_fail++;
                $display("FAIL resp_timeout: no resp_valid after %0d cycles, expected one", lat);
                break;
            end
            @(negedge clk_in);
        end
        rdata = resp_rdata_v[k];
        err   = resp_error_v[k];
        $display("txn dut%0d w=%0d size=%0d sgn=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 k, req_write, req_size, req_signed, req_addr, req_wdata, rdata, err, lat);
    endtask

    typedef struct {
        int k; bit w; logic [1:0] size; bit sgn;
        logic [31:0] addr; logic [31:0] wdata; int blat;
        logic [31:0] exp_rdata; bit exp_err; int exp_lat;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [31:0] rdata, e_rdata;
        bit          err, e_err;
        int          lat, e_lat, cyc;

        tbl = '{
            '{0, 0, 2'd2, 0, 32'h00010010, 32'h0,        2, 32'hDEADBEEF, 0, 17},
            '{0, 0, 2'd1, 1, 32'h00010002, 32'h0,        2, 32'hFFFF9234, 0, 9},
            '{0, 0, 2'd1, 0, 32'h00010002, 32'h0,        2, 32'h00009234, 0, 9},
            '{0, 0, 2'd2, 0, 32'h00010001, 32'h0,        1, 32'h00000000, 1, 1},
            '{0, 0, 2'd3, 0, 32'h00000000, 32'h0,        1, 32'h00000000, 1, 1},
            '{1, 0, 2'd3, 0, 32'h00000000, 32'h0,        1, 32'hDEAD0BAD, 1, 1},
            '{0, 1, 2'd1, 0, 32'h00010021, 32'h1234A55A, 1, 32'h00000000, 1, 1},
            '{1, 1, 2'd1, 0, 32'h00010021, 32'h1234A55A, 1, 32'h00000000, 0, 7},
            '{1, 0, 2'd1, 0, 32'h00010021, 32'h0,        1, 32'h0000A55A, 0, 7},
            '{0, 0, 2'd0, 1, 32'h00010022, 32'h0,        1, 32'hFFFFFFA5, 0, 4},
            '{1, 0, 2'd0, 0, 32'h00010022, 32'h0,        2, 32'h000000A5, 0, 5},
            '{0, 1, 2'd0, 0, 32'h00010050, 32'h000000C3, 2, 32'h00000000, 0, 5}
        };

        rst_in      = 1'b1;
        req_valid_v = 2'b00;
        req_write   = 1'b0;
        req_size    = 2'd0;
        req_signed  = 1'b0;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;

        poke(32'h00010002, 8'h34);
        poke(32'h00010003, 8'h92);
        poke(32'hFFFFFFFE, 8'h11);
        poke(32'hFFFFFFFF, 8'h22);
        poke(32'h00000000, 8'h33);
        poke(32'h00000001, 8'h44);
        for (int i = 0; i < 64; i++) poke(32'h00010040 + 32'(i), 8'($urandom));

        // Reset state
        repeat (3) @(negedge clk_in);
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", 32'(req_ready_v[k]), 32'h0);
            chk("rst_resp_valid", 32'(resp_valid_v[k]), 32'h0);
            chk("rst_resp_error", 32'(resp_error_v[k]), 32'h0);
            chk("rst_resp_rdata", resp_rdata_v[k], 32'h0);
            chk("rst_bus_addr", ba_v[k], 32'h0);
            chk("rst_bus_wdata", 32'(bw_v[k]), 32'h0);
            chk("rst_dispatch", 32'({dr_v[k], dw_v[k]}), 32'h0);
        end
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("ready_after_rst0", 32'(req_ready_v[0]), 32'h1);
        chk("ready_after_rst1", 32'(req_ready_v[1]), 32'h1);

        // Word store, 1-cycle bus: four byte writes, response 13 cycles after accept
        bus_lat = 1;
        disp_q.delete();
        ref_model(0, 1, 2'd2, 0, 32'h00010010, 32'hDEADBEEF, 1, e_rdata, e_err, e_lat);
        start_req(0, 1, 2'd2, 0, 32'h00010010, 32'hDEADBEEF);
        wait_resp(0, rdata, err, lat);
        chk("s1_lat", 32'(lat), 32'd13);
        chk("s1_err", 32'(err), 32'h0);
        chk("s1_rdata", rdata, 32'h0);
        chk("s1_ndisp", 32'(disp_q.size()), 32'd4);
        if (disp_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("s1_disp_write", 32'(disp_q[i].w), 32'h1);
                chk("s1_disp_addr", disp_q[i].a, 32'h00010010 + 32'(i));
            end
            chk("s1_data", {disp_q[3].d, disp_q[2].d, disp_q[1].d, disp_q[0].d}, 32'hDEADBEEF);
        end
        @(negedge clk_in);
        chk("s1_pulse_once", 32'(resp_valid_v[0]), 32'h0);

        // Directed table
        for (int t = 0; t < 12; t++) begin
            bus_lat = tbl[t].blat;
            disp_q.delete();
            ref_model(tbl[t].k, tbl[t].w, tbl[t].size, tbl[t].sgn, tbl[t].addr,
                      tbl[t].wdata, tbl[t].blat, e_rdata, e_err, e_lat);
            start_req(tbl[t].k, tbl[t].w, tbl[t].size, tbl[t].sgn, tbl[t].addr, tbl[t].wdata);
            wait_resp(tbl[t].k, rdata, err, lat);
            chk($sformatf("tbl%0d_rdata", t), rdata, tbl[t].exp_rdata);
            chk($sformatf("tbl%0d_err", t), 32'(err), 32'(tbl[t].exp_err));
            chk($sformatf("tbl%0d_lat", t), 32'(lat), 32'(tbl[t].exp_lat));
            if (tbl[t].exp_err) chk($sformatf("tbl%0d_nodisp", t), 32'(disp_q.size()), 32'h0);
        end

        // Unchecked alignment: word load wrapping through address zero
        bus_lat = 1;
        disp_q.delete();
        start_req(1, 0, 2'd2, 0, 32'hFFFFFFFE, 32'h0);
        wait_resp(1, rdata, err, lat);
        chk("s4_rdata", rdata, 32'h44332211);
        chk("s4_err", 32'(err), 32'h0);
        chk("s4_ndisp", 32'(disp_q.size()), 32'd4);
        if (disp_q.size() == 4) begin
            chk("s4_addr0", disp_q[0].a, 32'hFFFFFFFE);
            chk("s4_addr1", disp_q[1].a, 32'hFFFFFFFF);
            chk("s4_addr2", disp_q[2].a, 32'h00000000);
            chk("s4_addr3", disp_q[3].a, 32'h00000001);
        end

        // Signed byte load with the bus held busy before the first issue
        poke(32'h00000000, 8'h80);
        force_busy = 1'b1;
        repeat (2) @(negedge clk_in);
        disp_q.delete();
        start_req(0, 0, 2'd0, 1, 32'h00000000, 32'h0);
        repeat (5) @(negedge clk_in);
        chk("s5_held_nodisp", 32'(disp_q.size()), 32'h0);
        force_busy = 1'b0;
        wait_resp(0, rdata, err, lat);
        chk("s5_rdata", rdata, 32'hFFFFFF80);
        chk("s5_err", 32'(err), 32'h0);
        chk("s5_ndisp", 32'(disp_q.size()), 32'd1);

        // Reset during the wait of the second byte of a word store
        bus_lat = 1;
        disp_q.delete();
        start_req(0, 1, 2'd2, 0, 32'h00010030, 32'h55667788);
        cyc = 0;
        while (disp_q.size() < 2 && cyc < 40) begin
            @(negedge clk_in);
            cyc++;
        end
        chk("s6_reached_byte2", 32'(disp_q.size()), 32'd2);
        shadow[32'h00010030] = 8'h88;
        shadow[32'h00010031] = 8'h77;
        rst_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_in);
            chk("s6_rst_dispatch", 32'({dr_v[0], dw_v[0]}), 32'h0);
            chk("s6_rst_resp_valid", 32'(resp_valid_v[0]), 32'h0);
            chk("s6_rst_ready", 32'(req_ready_v[0]), 32'h0);
        end
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("s6_ready_after", 32'(req_ready_v[0]), 32'h1);
        chk("s6_no_resp", 32'(resp_valid_v[0]), 32'h0);
        chk("s6_no_more_disp", 32'(disp_q.size()), 32'd2);
        ref_model(0, 0, 2'd0, 0, 32'h00010031, 32'h0, 1, e_rdata, e_err, e_lat);
        start_req(0, 0, 2'd0, 0, 32'h00010031, 32'h0);
        wait_resp(0, rdata, err, lat);
        chk("s6_load_rdata", rdata, e_rdata);
        chk("s6_load_err", 32'(err), 32'(e_err));
        chk("s6_load_lat", 32'(lat), 32'(e_lat));

        // Random requests against the reference model
        for (int r = 0; r < 80; r++) begin
            int          k, blat, n;
            bit          w, sgn;
            logic [1:0]  size;
            logic [31:0] addr, wdata;
            k     = int'($urandom_range(0, 1));
            w     = 1'($urandom_range(0, 1));
            sgn   = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 3));
            addr  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7))
                                                : 32'h00010040 + 32'($urandom_range(0, 63));
            wdata = $urandom;
            blat  = int'($urandom_range(1, 2));
            n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
            bus_lat = blat;
            disp_q.delete();
            ref_model(k, w, size, sgn, addr, wdata, blat, e_rdata, e_err, e_lat);
            start_req(k, w, size, sgn, addr, wdata);
            wait_resp(k, rdata, err, lat);
            chk("rnd_rdata", rdata, e_rdata);
            chk("rnd_err", 32'(err), 32'(e_err));
            chk("rnd_lat", 32'(lat), 32'(e_lat));
            chk("rnd_ndisp", 32'(disp_q.size()), e_err ? 32'h0 : 32'(n));
        end

        repeat (3) @(negedge clk_in);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
